// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multi-cycle divider.
//   div_state_e : divider FSM states (IDLE / BUSY / DONE)
//   DIV_WIDTH   : default operand width
//   DIV_CYCLES  : restoring iterations per division (one per operand bit)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

endpackage

// File: rtl/div_if.sv
// div_if: E-stage <-> divider connection.
//   master (pipeline side): drives start, signed_div, a, b, annul;
//                           observes stall_divE, ready, result.
//   slave  (divider side) : the mirror image.
interface div_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 annul;
  logic                 stall_divE;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_divE, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_divE, ready, result
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   rem_i/quot_i : current partial remainder and dividend/quotient shift register
//   dvsr_i       : divisor magnitude
//   rem_o/quot_o : pair after shifting left by one and trying a subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // The remainder is always below the divisor, so WIDTH+1 bits hold the
    // shifted value and the MSB of the trial difference is its sign.
    shifted = {rem_i, quot_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_i};
    rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU for the execute stage.
//   clk, rst         : pipeline clock, synchronous active-high reset
//   bus.start        : E-stage instruction is DIV/DIVU
//   bus.signed_div   : 1 = DIV, 0 = DIVU
//   bus.a / bus.b    : dividend / divisor, sampled only when a division starts
//   bus.annul        : cancel the in-flight division
//   bus.stall_divE   : hold F/D/E while the division iterates
//   bus.ready        : one-cycle pulse when bus.result is valid
//   bus.result       : {remainder, quotient} for HI/LO, held until next DONE
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     rem_q, quot_q, dvsr_q, a_q;
  logic                 neg_quot_q, neg_rem_q, dz_q;
  logic [2*WIDTH-1:0]   result_q, result_fix;
  logic [WIDTH-1:0]     rem_n, quot_n;
  logic                 accept, last_step, stall, ready;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept    = (state_q == IDLE) && bus.start && !bus.annul;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.annul)     state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: begin
        // start is ignored here: the finished instruction is still in E.
        ready   = !bus.annul;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- operand capture / iteration ----
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_n),
    .quot_o (quot_n)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      quot_q     <= cond_neg(bus.a, bus.signed_div && bus.a[WIDTH-1]);
      dvsr_q     <= cond_neg(bus.b, bus.signed_div && bus.b[WIDTH-1]);
      rem_q      <= '0;
      a_q        <= bus.a;
      neg_quot_q <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_rem_q  <= bus.signed_div && bus.a[WIDTH-1];
      dz_q       <= (bus.b == '0);
    end else if (state_q == BUSY) begin
      rem_q  <= rem_n;
      quot_q <= quot_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept)                 cnt_q <= '0;
      else if (state_q == BUSY)   cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == DONE && !bus.annul) result_q <= result_fix;
    end
  end

  // ---- sign fix-up / result ----
  // Magnitude of the most negative dividend is 2^(WIDTH-1), which still fits
  // unsigned, so MIN / -1 yields MIN with remainder 0 and no special case.
  assign result_fix = dz_q ? {a_q, {WIDTH{1'b1}}}
                           : {cond_neg(rem_q, neg_rem_q), cond_neg(quot_q, neg_quot_q)};

  assign bus.stall_divE = stall;
  assign bus.ready      = ready;
  assign bus.result     = (state_q == DONE) ? result_fix : result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// A timeline model (cycle of acceptance plus arithmetic on wide integers)
// predicts stall_divE / ready / result on every falling edge; directed
// vectors with literal results pin the model.
module tb_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_div(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---- model + per-cycle compare ----
  bit          model_on = 1'b0;
  int          t0       = -1;
  logic [63:0] m_res    = 64'd0;
  logic [63:0] m_hold   = 64'd0;

  always @(negedge clk) begin : mdl
    int   k;
    logic acc, e_stall, e_ready;
    if (model_on) begin
      k       = (t0 >= 0) ? (cyc - t0) : -1;
      acc     = (t0 < 0) && bus.start && !bus.annul;
      e_stall = acc || (k >= 1 && k <= W);
      e_ready = (k == W + 1) && !bus.annul;
      chk("stall", 64'(bus.stall_divE), 64'(e_stall));
      chk("ready", 64'(bus.ready), 64'(e_ready));
      if (e_ready)       chk("result", bus.result, m_res);
      else if (k != W+1) chk("result_hold", bus.result, m_hold);
      if (rst) begin
        t0     = -1;
        m_hold = 64'd0;
      end else if (acc) begin
        t0    = cyc;
        m_res = model_div(bus.signed_div, bus.a, bus.b);
      end else if (k >= 1 && k <= W && bus.annul) begin
        t0 = -1;
      end else if (k == W + 1) begin
        if (!bus.annul) m_hold = m_res;
        t0 = -1;
      end
    end
  end

  // ---- directed stimulus ----
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
    int          lat, nstall;
    logic        got;
    logic [63:0] res;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = sg; bus.a = a; bus.b = b;
    lat = 0; nstall = 0; got = 1'b0; res = 64'd0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.stall_divE) nstall++;
      if (bus.ready) begin
        got = 1'b1;
        res = bus.result;
      end else begin
        lat++;
      end
      // Forwarding updates during the stall must not disturb the division.
      if (i == 1) begin
        bus.a = ~a;
        bus.b = a ^ b;
      end
    end
    chk({name, "_seen"}, 64'(got), 64'd1);
    chk({name, "_res"}, res, exp);
    chk({name, "_lat"}, 64'(lat), 64'd33);
    chk({name, "_stall_cycles"}, 64'(nstall), 64'd33);
  endtask

  task automatic end_op();
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int nready;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0; bus.annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(bus.stall_divE), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7"); end_op();
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2"); end_op();
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_m1"); end_op();
    run_div(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, "divu_by0"); end_op();
    run_div(1'b1, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF, "div_by0"); end_op();
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_m2"); end_op();
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, "divu_max_16"); end_op();

    // annul ten cycles into the division
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd50; bus.b = 32'd3;
    repeat (10) @(posedge clk); #1;
    bus.annul = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("annul_stall_low", 64'(bus.stall_divE), 64'd0);
    nready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) nready++;
    end
    chk("annul_no_ready", 64'(nready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "divu_9_3"); end_op();

    // back-to-back divides
    run_div(1'b0, 32'd12, 32'd5, 64'h00000002_00000002, "b2b_first");
    run_div(1'b0, 32'd7, 32'd7, 64'h00000000_00000001, "b2b_second");
    end_op();

    // reset in the middle of BUSY
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd1000; bus.b = 32'd3;
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 64'(bus.stall_divE), 64'd0);
    chk("midrst_ready", 64'(bus.ready), 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, "div_m100_7"); end_op();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the execute stage of the five-stage MIPS pipeline. It accepts a DIV/DIVU in E, raises `stall_divE` to the hazard unit so F/D/E are held while it iterates, then presents `{HI=remainder, LO=quotient}` for the single cycle in which the instruction leaves E. The HI/LO write enable travels down the pipeline with the instruction.

## Interface
Parameters:
- `WIDTH`, 32, operand width; quotient and remainder are each `WIDTH` bits; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  E-stage instruction is DIV/DIVU (`divE`).
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `a`  in  WIDTH  dividend (forwarded rs value in E).
- `b`  in  WIDTH  divisor (forwarded rt value in E).
- `annul`  in  1  cancel the in-flight division (exception or redirect).
- `stall_divE`  out  1  to the hazard unit; holds F/D/E while high.
- `ready`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  2*WIDTH  `{remainder, quotient}` destined for HI/LO.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if `start && !annul`, latch operand magnitudes, sign flags, `signed_div` and a divisor-zero flag; clear counter; go to BUSY. Otherwise stay.
- BUSY: one restoring step per cycle. Shift `{rem, quot}` left by 1; trial = `rem[WIDTH:0] - {1'b0, |b|}` (WIDTH+1 bits). If the trial is non-negative, rem takes the trial value and the new quotient LSB is 1. Otherwise rem is unchanged and the LSB is 0. Counter increments; after step `WIDTH` go to DONE.
- DONE: `ready=1`, `stall_divE=0`; apply sign fix-up. Quotient is negated when signed and the operand signs differ; remainder takes the sign of the dividend. Go to IDLE unconditionally. `start` is ignored in DONE because the same instruction is still in E.
- Divide by zero (latched `b==0`): `result = {a_latched, {WIDTH{1'b1}}}` regardless of `signed_div`, with normal latency.
- Signed `0x80000000 / 0xFFFFFFFF`: magnitude 2^31 fits unsigned. Quotient = 0x80000000, remainder = 0. No trap.
- `stall_divE = (IDLE && start && !annul) || BUSY` (combinational). It must be high in the `start` cycle so E is frozen before the next edge.
- `annul` in BUSY or DONE: next state IDLE; `ready` suppressed in the annul cycle.
- `rst` at any point: next state IDLE.
- Operands are sampled only in the IDLE->BUSY cycle. Later changes on `a`/`b` (e.g. forwarding updates during the stall) are ignored.

## Timing
- Reset values: state=IDLE, `stall_divE=0`, `ready=0`, `result=0`, counter=0.
- `start` seen in IDLE at cycle t: `stall_divE` is high in cycles t..t+WIDTH (33 cycles for WIDTH=32). `ready` pulses at t+WIDTH+1 with `stall_divE` low. The instruction moves to M on that edge.
- Back-to-back divides: the second DIV enters E the cycle after DONE (IDLE), so there is no bubble beyond the FSM.
- `result` holds its value after DONE until the next DONE. Consumers must qualify it with `ready`.

## Structure
- Shared package `div_pkg`: state enum (IDLE/BUSY/DONE) and `DIV_CYCLES = WIDTH` constant, reused by the hazard unit testbench.
- Sub-module `div_step`: combinational single restoring iteration. Inputs are the `{rem, quot}` pair and the divisor magnitude; outputs are the next pair.
- Abs/negate logic lives inline in `div_unit`.

## Test plan
- DIVU a=100, b=7 -> `ready` at t+33, `result=0x00000002_0000000E`; `stall_divE` high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `result=0xFFFFFFFF_FFFFFFFD` (r=-1, q=-3).
- DIV a=0x80000000, b=0xFFFFFFFF -> `result=0x00000000_80000000`.
- DIVU a=5, b=0 -> `result=0x00000005_FFFFFFFF`, same latency.
- Assert `annul` at t+10 -> IDLE at t+11; no `ready`; `stall_divE` low from t+11. Then a new DIVU 9/3 -> `result=0x00000000_00000003`.
- Two DIVUs back-to-back (12/5 then 7/7) -> `ready` pulses at t+33 and t+67; results `0x00000002_00000002` then `0x00000000_00000001`. Separately, `rst` asserted mid-BUSY -> all outputs return to reset values the next cycle.
